// File: rtl/reorder_buffer_if.sv
// Issue, writeback, operand-query and retire signals of the reorder buffer.
// master = issue/execute side, slave = the buffer itself.
interface reorder_buffer_if #(
  parameter int POS_W  = 4,
  parameter int DATA_W = 32
);
  logic              rdy;
  logic              issue;
  logic [1:0]        issue_type;
  logic [4:0]        issue_rd;
  logic [DATA_W-1:0] issue_pred_pc;
  logic              issue_ready;
  logic [DATA_W-1:0] issue_val;
  logic [POS_W-1:0]  issue_rob_pos;
  logic              full;
  logic              alu_wb;
  logic [POS_W-1:0]  alu_pos;
  logic [DATA_W-1:0] alu_val;
  logic [DATA_W-1:0] alu_next_pc;
  logic              lsb_wb;
  logic [POS_W-1:0]  lsb_pos;
  logic [DATA_W-1:0] lsb_val;
  logic [POS_W-1:0]  q1_pos;
  logic              q1_ready;
  logic [DATA_W-1:0] q1_val;
  logic [POS_W-1:0]  q2_pos;
  logic              q2_ready;
  logic [DATA_W-1:0] q2_val;
  logic              commit;
  logic [4:0]        commit_rd;
  logic [DATA_W-1:0] commit_val;
  logic [POS_W-1:0]  commit_rob_pos;
  logic              commit_store;
  logic              rollback;
  logic [DATA_W-1:0] rollback_pc;
  logic [POS_W-1:0]  head_pos;

  modport master (
    output rdy, issue, issue_type, issue_rd, issue_pred_pc, issue_ready, issue_val,
    output alu_wb, alu_pos, alu_val, alu_next_pc, lsb_wb, lsb_pos, lsb_val,
    output q1_pos, q2_pos,
    input  issue_rob_pos, full, q1_ready, q1_val, q2_ready, q2_val,
    input  commit, commit_rd, commit_val, commit_rob_pos, commit_store,
    input  rollback, rollback_pc, head_pos
  );

  modport slave (
    input  rdy, issue, issue_type, issue_rd, issue_pred_pc, issue_ready, issue_val,
    input  alu_wb, alu_pos, alu_val, alu_next_pc, lsb_wb, lsb_pos, lsb_val,
    input  q1_pos, q2_pos,
    output issue_rob_pos, full, q1_ready, q1_val, q2_ready, q2_val,
    output commit, commit_rd, commit_val, commit_rob_pos, commit_store,
    output rollback, rollback_pc, head_pos
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order retire to the register file, result capture
// from the ALU/LSB buses, and full flush on a mispredicted branch.
module reorder_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int POS_W    = 4,
  parameter int DATA_W   = 32
) (
  input logic             clk,
  input logic             rst,
  reorder_buffer_if.slave bus
);
  localparam logic [1:0] T_STORE  = 2'd1;
  localparam logic [1:0] T_BRANCH = 2'd2;

  typedef struct packed {
    logic              busy;
    logic              ready;
    logic [1:0]        kind;
    logic [4:0]        rd;
    logic [DATA_W-1:0] val;
    logic [DATA_W-1:0] pred_pc;
    logic [DATA_W-1:0] resolved_pc;
  } entry_t;

  entry_t           rob [ROB_SIZE];
  logic [POS_W-1:0] head, tail;
  logic [POS_W:0]   count;

  entry_t h;
  logic   retire, mispredict, accept, wb_ok;

  assign h          = rob[head];
  assign retire     = h.busy && h.ready;
  assign mispredict = retire && h.kind == T_BRANCH && h.resolved_pc != h.pred_pc;
  assign bus.full          = count == (POS_W+1)'(ROB_SIZE);
  assign bus.issue_rob_pos = tail;
  assign bus.head_pos      = head;
  // the rollback-high cycle drains issue/writeback traffic for squashed work
  assign accept = bus.issue && !bus.full && !bus.rollback;
  assign wb_ok  = !bus.rollback;

  logic [1:0][POS_W-1:0]  qpos;
  logic [1:0]             qrdy;
  logic [1:0][DATA_W-1:0] qval;

  assign qpos         = {bus.q2_pos, bus.q1_pos};
  assign bus.q1_ready = qrdy[0];
  assign bus.q1_val   = qval[0];
  assign bus.q2_ready = qrdy[1];
  assign bus.q2_val   = qval[1];

  always_comb begin
    qrdy = '0;
    qval = '0;
    for (int i = 0; i < 2; i++) begin
      if (rob[qpos[i]].busy) begin
        if (bus.alu_wb && bus.alu_pos == qpos[i]) begin
          qrdy[i] = 1'b1;
          qval[i] = bus.alu_val;
        end else if (bus.lsb_wb && bus.lsb_pos == qpos[i]) begin
          qrdy[i] = 1'b1;
          qval[i] = bus.lsb_val;
        end else begin
          qrdy[i] = rob[qpos[i]].ready;
          qval[i] = rob[qpos[i]].val;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        rob[i].busy  <= 1'b0;
        rob[i].ready <= 1'b0;
      end
      bus.commit         <= 1'b0;
      bus.commit_rd      <= '0;
      bus.commit_val     <= '0;
      bus.commit_rob_pos <= '0;
      bus.commit_store   <= 1'b0;
      bus.rollback       <= 1'b0;
      bus.rollback_pc    <= '0;
    end else if (bus.rdy) begin
      bus.commit       <= retire;
      bus.commit_store <= retire && h.kind == T_STORE;
      bus.rollback     <= mispredict;
      if (retire) begin
        bus.commit_rob_pos <= head;
        bus.commit_val     <= h.val;
        bus.commit_rd      <= (h.kind == T_STORE) ? 5'd0 : h.rd;
      end
      if (mispredict) begin
        bus.rollback_pc <= h.resolved_pc;
        head  <= '0;
        tail  <= '0;
        count <= '0;
        for (int i = 0; i < ROB_SIZE; i++) begin
          rob[i].busy  <= 1'b0;
          rob[i].ready <= 1'b0;
        end
      end else begin
        if (wb_ok && bus.lsb_wb && rob[bus.lsb_pos].busy) begin
          rob[bus.lsb_pos].ready <= 1'b1;
          rob[bus.lsb_pos].val   <= bus.lsb_val;
        end
        if (wb_ok && bus.alu_wb && rob[bus.alu_pos].busy) begin
          rob[bus.alu_pos].ready       <= 1'b1;
          rob[bus.alu_pos].val         <= bus.alu_val;
          rob[bus.alu_pos].resolved_pc <= bus.alu_next_pc;
        end
        if (retire) begin
          rob[head].busy  <= 1'b0;
          rob[head].ready <= 1'b0;
          head <= head + 1'b1;
        end
        // a ready-at-issue branch assumes its prediction holds
        if (accept) begin
          rob[tail] <= '{busy: 1'b1, ready: bus.issue_ready, kind: bus.issue_type,
                         rd: bus.issue_rd, val: bus.issue_val,
                         pred_pc: bus.issue_pred_pc, resolved_pc: bus.issue_pred_pc};
          tail <= tail + 1'b1;
        end
        count <= count + (POS_W+1)'(accept) - (POS_W+1)'(retire);
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed-vector bench for reorder_buffer.
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  reorder_buffer_if #(.POS_W(4), .DATA_W(32)) bus ();
  reorder_buffer #(.ROB_SIZE(16), .POS_W(4), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic clear_in();
    bus.rdy = 1'b1; bus.issue = 1'b0; bus.issue_type = 2'd0; bus.issue_rd = 5'd0;
    bus.issue_pred_pc = '0; bus.issue_ready = 1'b0; bus.issue_val = '0;
    bus.alu_wb = 1'b0; bus.alu_pos = '0; bus.alu_val = '0; bus.alu_next_pc = '0;
    bus.lsb_wb = 1'b0; bus.lsb_pos = '0; bus.lsb_val = '0;
    bus.q1_pos = '0; bus.q2_pos = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic issue_op(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] ppc,
                          input logic rdy_at_issue, input logic [31:0] v);
    bus.issue = 1'b1; bus.issue_type = t; bus.issue_rd = rd; bus.issue_pred_pc = ppc;
    bus.issue_ready = rdy_at_issue; bus.issue_val = v;
    step();
    bus.issue = 1'b0; bus.issue_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.full !== 1'b0 || bus.issue_rob_pos !== 4'd0 || bus.head_pos !== 4'd0) begin
      n_fail++; $display("FAIL reset_ptrs: full=%b tail=%0d head=%0d want 0 0 0", bus.full, bus.issue_rob_pos, bus.head_pos);
    end
    n_checks++;
    if (bus.commit !== 1'b0 || bus.rollback !== 1'b0 || bus.commit_store !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses: commit=%b rollback=%b store=%b want 0", bus.commit, bus.rollback, bus.commit_store);
    end
    for (int p = 0; p < 16; p++) begin
      bus.q1_pos = 4'(p);
      #1;
      n_checks++;
      if (bus.q1_ready !== 1'b0 || bus.q1_val !== 32'd0) begin
        n_fail++; $display("FAIL reset_query pos%0d: ready=%b val=%h want 0 0", p, bus.q1_ready, bus.q1_val);
      end
    end
    bus.q1_pos = '0;
  endtask

  task automatic test_in_order();
    do_reset();
    issue_op(2'd0, 5'd1, 32'h0, 1'b0, 32'h0);
    issue_op(2'd0, 5'd2, 32'h0, 1'b0, 32'h0);
    issue_op(2'd0, 5'd3, 32'h0, 1'b0, 32'h0);
    n_checks++;
    if (bus.issue_rob_pos !== 4'd3) begin
      n_fail++; $display("FAIL inorder_tail: got %0d want 3", bus.issue_rob_pos);
    end
    bus.alu_wb = 1'b1; bus.alu_pos = 4'd2; bus.alu_val = 32'h22;
    step();
    n_checks++;
    if (bus.commit !== 1'b0) begin
      n_fail++; $display("FAIL inorder_wait: commit=%b want 0", bus.commit);
    end
    bus.alu_pos = 4'd0; bus.alu_val = 32'h11;
    step();
    bus.alu_wb = 1'b0;
    bus.lsb_wb = 1'b1; bus.lsb_pos = 4'd1; bus.lsb_val = 32'h33;
    step();
    bus.lsb_wb = 1'b0;
    n_checks++;
    if ({bus.commit, bus.commit_rob_pos, bus.commit_rd, bus.commit_val} !== {1'b1, 4'd0, 5'd1, 32'h11}) begin
      n_fail++; $display("FAIL inorder_c0: commit=%b pos=%0d rd=%0d val=%h want 1 0 1 11", bus.commit, bus.commit_rob_pos, bus.commit_rd, bus.commit_val);
    end
    step();
    n_checks++;
    if ({bus.commit, bus.commit_rob_pos, bus.commit_rd, bus.commit_val} !== {1'b1, 4'd1, 5'd2, 32'h33}) begin
      n_fail++; $display("FAIL inorder_c1: commit=%b pos=%0d rd=%0d val=%h want 1 1 2 33", bus.commit, bus.commit_rob_pos, bus.commit_rd, bus.commit_val);
    end
    step();
    n_checks++;
    if ({bus.commit, bus.commit_rob_pos, bus.commit_rd, bus.commit_val} !== {1'b1, 4'd2, 5'd3, 32'h22}) begin
      n_fail++; $display("FAIL inorder_c2: commit=%b pos=%0d rd=%0d val=%h want 1 2 3 22", bus.commit, bus.commit_rob_pos, bus.commit_rd, bus.commit_val);
    end
    step();
    n_checks++;
    if (bus.commit !== 1'b0 || bus.head_pos !== 4'd3) begin
      n_fail++; $display("FAIL inorder_idle: commit=%b head=%0d want 0 3", bus.commit, bus.head_pos);
    end
  endtask

  task automatic test_fill_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) issue_op(2'd0, 5'(i + 1), 32'h0, 1'b0, 32'h0);
    n_checks++;
    if (bus.full !== 1'b1 || bus.issue_rob_pos !== 4'd0) begin
      n_fail++; $display("FAIL fill_full: full=%b tail=%0d want 1 0", bus.full, bus.issue_rob_pos);
    end
    issue_op(2'd0, 5'd31, 32'h0, 1'b0, 32'h0);
    n_checks++;
    if (bus.full !== 1'b1 || bus.issue_rob_pos !== 4'd0) begin
      n_fail++; $display("FAIL fill_17th: full=%b tail=%0d want 1 0", bus.full, bus.issue_rob_pos);
    end
    bus.alu_wb = 1'b1; bus.alu_pos = 4'd0; bus.alu_val = 32'hA0;
    bus.lsb_wb = 1'b1; bus.lsb_pos = 4'd1; bus.lsb_val = 32'hA1;
    step();
    clear_in();
    step();
    n_checks++;
    if ({bus.commit, bus.commit_rob_pos, bus.commit_rd, bus.commit_val, bus.full} !== {1'b1, 4'd0, 5'd1, 32'hA0, 1'b0}) begin
      n_fail++; $display("FAIL fill_retire0: commit=%b pos=%0d rd=%0d val=%h full=%b want 1 0 1 a0 0", bus.commit, bus.commit_rob_pos, bus.commit_rd, bus.commit_val, bus.full);
    end
    issue_op(2'd0, 5'd17, 32'h0, 1'b0, 32'h0);
    n_checks++;
    if ({bus.commit, bus.commit_rob_pos, bus.full, bus.issue_rob_pos, bus.head_pos} !== {1'b1, 4'd1, 1'b0, 4'd1, 4'd2}) begin
      n_fail++; $display("FAIL fill_issue_retire: commit=%b pos=%0d full=%b tail=%0d head=%0d want 1 1 0 1 2", bus.commit, bus.commit_rob_pos, bus.full, bus.issue_rob_pos, bus.head_pos);
    end
    issue_op(2'd0, 5'd18, 32'h0, 1'b0, 32'h0);
    n_checks++;
    if (bus.full !== 1'b1 || bus.issue_rob_pos !== 4'd2) begin
      n_fail++; $display("FAIL fill_refull: full=%b tail=%0d want 1 2", bus.full, bus.issue_rob_pos);
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    issue_op(2'd2, 5'd0, 32'h104, 1'b0, 32'h0);
    issue_op(2'd0, 5'd4, 32'h0, 1'b1, 32'h44);
    issue_op(2'd0, 5'd5, 32'h0, 1'b0, 32'h0);
    issue_op(2'd0, 5'd6, 32'h0, 1'b0, 32'h0);
    bus.alu_wb = 1'b1; bus.alu_pos = 4'd0; bus.alu_val = 32'h104; bus.alu_next_pc = 32'h200;
    step();
    clear_in();
    bus.issue = 1'b1; bus.issue_rd = 5'd9;
    bus.lsb_wb = 1'b1; bus.lsb_pos = 4'd2; bus.lsb_val = 32'h77;
    step();
    clear_in();
    n_checks++;
    if ({bus.commit, bus.commit_rob_pos, bus.rollback, bus.rollback_pc} !== {1'b1, 4'd0, 1'b1, 32'h200}) begin
      n_fail++; $display("FAIL mp_rollback: commit=%b pos=%0d rollback=%b pc=%h want 1 0 1 200", bus.commit, bus.commit_rob_pos, bus.rollback, bus.rollback_pc);
    end
    n_checks++;
    if (bus.full !== 1'b0 || bus.issue_rob_pos !== 4'd0 || bus.head_pos !== 4'd0) begin
      n_fail++; $display("FAIL mp_ptrs: full=%b tail=%0d head=%0d want 0 0 0", bus.full, bus.issue_rob_pos, bus.head_pos);
    end
    bus.q1_pos = 4'd1; bus.q2_pos = 4'd2;
    #1;
    n_checks++;
    if (bus.q1_ready !== 1'b0 || bus.q2_ready !== 1'b0) begin
      n_fail++; $display("FAIL mp_flushed: q1_ready=%b q2_ready=%b want 0 0", bus.q1_ready, bus.q2_ready);
    end
    issue_op(2'd0, 5'd5, 32'h0, 1'b1, 32'h55);
    n_checks++;
    if (bus.rollback !== 1'b0 || bus.commit !== 1'b0 || bus.issue_rob_pos !== 4'd0) begin
      n_fail++; $display("FAIL mp_drain: rollback=%b commit=%b tail=%0d want 0 0 0", bus.rollback, bus.commit, bus.issue_rob_pos);
    end
    issue_op(2'd0, 5'd5, 32'h0, 1'b1, 32'h55);
    step();
    n_checks++;
    if ({bus.commit, bus.commit_rob_pos, bus.commit_rd, bus.commit_val} !== {1'b1, 4'd0, 5'd5, 32'h55}) begin
      n_fail++; $display("FAIL mp_resume: commit=%b pos=%0d rd=%0d val=%h want 1 0 5 55", bus.commit, bus.commit_rob_pos, bus.commit_rd, bus.commit_val);
    end
  endtask

  task automatic test_branch_store();
    do_reset();
    issue_op(2'd2, 5'd1, 32'h104, 1'b0, 32'h0);
    issue_op(2'd1, 5'd7, 32'h0, 1'b0, 32'h0);
    bus.alu_wb = 1'b1; bus.alu_pos = 4'd0; bus.alu_val = 32'h8; bus.alu_next_pc = 32'h104;
    bus.lsb_wb = 1'b1; bus.lsb_pos = 4'd1; bus.lsb_val = 32'hDEAD;
    step();
    clear_in();
    step();
    n_checks++;
    if ({bus.commit, bus.commit_rob_pos, bus.commit_rd, bus.commit_val, bus.rollback, bus.commit_store} !== {1'b1, 4'd0, 5'd1, 32'h8, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL br_ok: commit=%b pos=%0d rd=%0d val=%h rb=%b st=%b want 1 0 1 8 0 0", bus.commit, bus.commit_rob_pos, bus.commit_rd, bus.commit_val, bus.rollback, bus.commit_store);
    end
    step();
    n_checks++;
    if ({bus.commit, bus.commit_rob_pos, bus.commit_rd, bus.commit_val, bus.commit_store} !== {1'b1, 4'd1, 5'd0, 32'hDEAD, 1'b1}) begin
      n_fail++; $display("FAIL store_retire: commit=%b pos=%0d rd=%0d val=%h st=%b want 1 1 0 dead 1", bus.commit, bus.commit_rob_pos, bus.commit_rd, bus.commit_val, bus.commit_store);
    end
    step();
    n_checks++;
    if ({bus.commit, bus.commit_store, bus.commit_rob_pos, bus.commit_val} !== {1'b0, 1'b0, 4'd1, 32'hDEAD}) begin
      n_fail++; $display("FAIL payload_hold: commit=%b st=%b pos=%0d val=%h want 0 0 1 dead", bus.commit, bus.commit_store, bus.commit_rob_pos, bus.commit_val);
    end
  endtask

  task automatic test_forwarding();
    do_reset();
    for (int i = 0; i < 6; i++) issue_op(2'd0, 5'(i + 1), 32'h0, 1'b0, 32'h0);
    bus.alu_wb = 1'b1; bus.alu_pos = 4'd5; bus.alu_val = 32'hABCD;
    bus.lsb_wb = 1'b1; bus.lsb_pos = 4'd4; bus.lsb_val = 32'h4444;
    bus.q1_pos = 4'd5; bus.q2_pos = 4'd4;
    #1;
    n_checks++;
    if ({bus.q1_ready, bus.q1_val, bus.q2_ready, bus.q2_val} !== {1'b1, 32'hABCD, 1'b1, 32'h4444}) begin
      n_fail++; $display("FAIL fwd_bus: q1=%b/%h q2=%b/%h want 1/abcd 1/4444", bus.q1_ready, bus.q1_val, bus.q2_ready, bus.q2_val);
    end
    step();
    clear_in();
    bus.q1_pos = 4'd5; bus.q2_pos = 4'd6;
    #1;
    n_checks++;
    if ({bus.q1_ready, bus.q1_val, bus.q2_ready, bus.q2_val} !== {1'b1, 32'hABCD, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL fwd_stored: q1=%b/%h q2=%b/%h want 1/abcd 0/0", bus.q1_ready, bus.q1_val, bus.q2_ready, bus.q2_val);
    end
    n_checks++;
    if (bus.commit !== 1'b0) begin
      n_fail++; $display("FAIL fwd_no_commit: commit=%b want 0", bus.commit);
    end
  endtask

  task automatic test_rdy_and_reset();
    do_reset();
    issue_op(2'd0, 5'd3, 32'h0, 1'b1, 32'h99);
    bus.rdy = 1'b0;
    step();
    n_checks++;
    if (bus.commit !== 1'b0 || bus.issue_rob_pos !== 4'd1) begin
      n_fail++; $display("FAIL stall_hold: commit=%b tail=%0d want 0 1", bus.commit, bus.issue_rob_pos);
    end
    bus.rdy = 1'b1;
    step();
    bus.rdy = 1'b0;
    step();
    n_checks++;
    if (bus.commit !== 1'b1 || bus.commit_val !== 32'h99) begin
      n_fail++; $display("FAIL stall_pulse_hold: commit=%b val=%h want 1 99", bus.commit, bus.commit_val);
    end
    bus.rdy = 1'b1;
    issue_op(2'd0, 5'd4, 32'h0, 1'b1, 32'h5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (bus.commit !== 1'b0 || bus.commit_val !== 32'h0 || bus.issue_rob_pos !== 4'd0) begin
      n_fail++; $display("FAIL mid_reset: commit=%b val=%h tail=%0d want 0 0 0", bus.commit, bus.commit_val, bus.issue_rob_pos);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    test_reset();
    test_in_order();
    test_fill_wrap();
    test_mispredict();
    test_branch_store();
    test_forwarding();
    test_rdy_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
